// File: rtl/time_of_day_counter.sv
// BCD hh:mm:ss time-of-day counter advanced by a synchronised 1 Hz strobe; time updates 3 clk_50MHz edges after clk_1Hz rises.
// Loads and carry pulses are registered. Optional alarm compare is built only when TOD_ALARM_EN is defined.
module time_of_day_counter (
  input  logic       clk_50MHz,
  input  logic       reset,
  input  logic       clk_1Hz,
  input  logic       run,
  input  logic       load_en,
  input  logic [7:0] load_hh,
  input  logic [7:0] load_mm,
  input  logic [7:0] load_ss,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       sec_tick,
  output logic       min_carry,
  output logic       day_wrap,
  output logic       load_err
`ifdef TOD_ALARM_EN
  ,
  input  logic       alarm_set,
  input  logic       alarm_ack,
  output logic       alarm
`endif
);

  logic       s1, s2, s3;
  logic       tick, tick_adv;
  logic       ss_wrap, mm_wrap, hh_wrap;
  logic [7:0] ss_n, mm_n, hh_n;
  logic       load_ok, load_rej;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) bcd_inc = {v[7:4] + 4'd1, 4'h0};
    else                bcd_inc = {v[7:4], v[3:0] + 4'd1};
  endfunction

  // With both nibbles <= 9 the packed BCD value orders the same as its decimal value.
  function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max);
    bcd_ok = (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
  endfunction

  assign tick     = s2 & ~s3;
  assign tick_adv = tick & run & ~load_en;
  assign ss_wrap  = (ss == 8'h59);
  assign mm_wrap  = (mm == 8'h59);
  assign hh_wrap  = (hh == 8'h23);
  assign load_ok  = bcd_ok(load_hh, 8'h23) && bcd_ok(load_mm, 8'h59) && bcd_ok(load_ss, 8'h59);

  always_comb begin
    ss_n = bcd_inc(ss);
    mm_n = mm;
    hh_n = hh;
    if (ss_wrap) begin
      ss_n = 8'h00;
      mm_n = mm_wrap ? 8'h00 : bcd_inc(mm);
      if (mm_wrap) hh_n = hh_wrap ? 8'h00 : bcd_inc(hh);
    end
  end

`ifdef TOD_ALARM_EN
  logic       alarm_ok;
  logic       armed;
  logic [7:0] alarm_hh, alarm_mm;

  assign alarm_ok = bcd_ok(load_hh, 8'h23) && bcd_ok(load_mm, 8'h59);
  assign load_rej = (load_en & ~load_ok) | (alarm_set & ~alarm_ok);

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      armed    <= 1'b0;
      alarm_hh <= 8'h00;
      alarm_mm <= 8'h00;
      alarm    <= 1'b0;
    end else begin
      if (alarm_set && alarm_ok) begin
        armed    <= 1'b1;
        alarm_hh <= load_hh;
        alarm_mm <= load_mm;
      end
      // Match can only occur on a minute rollover, so it must win over the min_carry clear.
      if (armed && tick_adv && ss_wrap && hh_n == alarm_hh && mm_n == alarm_mm)
        alarm <= 1'b1;
      else if (alarm_ack || (tick_adv && ss_wrap))
        alarm <= 1'b0;
    end
  end
`else
  assign load_rej = load_en & ~load_ok;
`endif

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      s3        <= 1'b0;
      hh        <= 8'h00;
      mm        <= 8'h00;
      ss        <= 8'h00;
      sec_tick  <= 1'b0;
      min_carry <= 1'b0;
      day_wrap  <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      s1        <= clk_1Hz;
      s2        <= s1;
      s3        <= s2;
      sec_tick  <= 1'b0;
      min_carry <= 1'b0;
      day_wrap  <= 1'b0;
      load_err  <= load_rej;
      if (load_en) begin
        if (load_ok) begin
          hh <= load_hh;
          mm <= load_mm;
          ss <= load_ss;
        end
      end else if (tick_adv) begin
        hh        <= hh_n;
        mm        <= mm_n;
        ss        <= ss_n;
        sec_tick  <= 1'b1;
        min_carry <= ss_wrap;
        day_wrap  <= ss_wrap & mm_wrap & hh_wrap;
      end
    end
  end

endmodule

// File: doc/time_of_day_counter.md
TIME_OF_DAY_COUNTER -- requirements
Module: time_of_day_counter

Interface
REQ-001 SHALL have port clk_50MHz  input  1  sole system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port clk_1Hz  input  1  square wave from the upstream 1 Hz divider; treated as asynchronous data, never used as a clock.
REQ-004 SHALL have port run  input  1  1 = count seconds, 0 = hold time.
REQ-005 SHALL have port load_en  input  1  one-cycle request to load time from load_hh/load_mm/load_ss.
REQ-006 SHALL have ports load_hh, load_mm, load_ss  input  8 each  packed BCD (tens[7:4], ones[3:0]).
REQ-007 SHALL have ports hh, mm, ss  output  8 each  current time, packed BCD, registered.
REQ-008 SHALL have port sec_tick  output  1  one-cycle pulse on each seconds advance.
REQ-009 SHALL have port min_carry  output  1  one-cycle pulse when ss wraps 59->00.
REQ-010 SHALL have port day_wrap  output  1  one-cycle pulse when 23:59:59 -> 00:00:00.
REQ-011 SHALL have port load_err  output  1  one-cycle pulse when a load/alarm-set request is rejected.

Function
REQ-012 SHALL synchronise clk_1Hz through two flops (s1, s2) and hold prior s2 in s3; tick = s2 & ~s3.
REQ-013 SHALL advance time at the 3rd rising clk_50MHz edge after clk_1Hz rises; falling edges of clk_1Hz have no effect.
REQ-014 SHALL ignore tick while run = 0; the synchroniser keeps running so no stale tick fires when run returns to 1.
REQ-015 SHALL count ss 00..59, mm 00..59, hh 00..23 in BCD; ones digit 9 -> 0 with tens increment; no binary values ever appear on outputs.
REQ-016 SHALL assert sec_tick, min_carry, day_wrap in the same cycle the registered outputs take the new value.
REQ-017 SHALL on load_en validate: every nibble <= 9, hh <= 0x23, mm <= 0x59, ss <= 0x59.
REQ-018 SHALL on valid load write hh/mm/ss at the next edge; on invalid load keep time unchanged and pulse load_err next cycle.
REQ-019 SHALL give load_en priority over a coincident tick; that tick is discarded and no sec_tick/min_carry/day_wrap pulses.
REQ-020 SHALL not generate carry pulses as a result of a load, even when loading 00:00:00.

Reset
REQ-021 SHALL on reset set hh = mm = ss = 0x00, s1 = s2 = s3 = 0, all pulse outputs 0.
REQ-022 SHALL let reset override load_en, tick and (if present) alarm inputs in the same cycle.
REQ-023 SHALL, if clk_1Hz is high when reset deasserts, produce one tick 3 edges later (s3 reset to 0); this is intended.

Configuration
REQ-024 SHALL compile alarm logic only when macro TOD_ALARM_EN is defined.
REQ-025 With TOD_ALARM_EN: add ports alarm_set (in 1), alarm_ack (in 1), alarm (out 1); alarm_set latches load_hh/load_mm as alarm time and arms it, validated per REQ-017 (load_ss ignored), invalid -> load_err and armed state unchanged.
REQ-026 With TOD_ALARM_EN: alarm SHALL rise in the cycle time becomes alarm_hh:alarm_mm:00 via a tick while armed; a load to that time SHALL NOT raise alarm; alarm clears on alarm_ack or at the next min_carry; reset clears alarm, disarms, alarm time 00:00.
REQ-027 Without TOD_ALARM_EN: ports alarm_set, alarm_ack, alarm SHALL not exist; no alarm registers.

Verification
REQ-028 Reset, then 3 rising clk_1Hz edges with run=1 -> ss = 0x03, 3 sec_tick pulses, each 3 clocks after clk_1Hz rise.
REQ-029 Load 23:59:59, one clk_1Hz rise -> 00:00:00 with sec_tick, min_carry, day_wrap all high for exactly 1 cycle.
REQ-030 Load hh=0x24 (and separately ss=0x5A) -> load_err 1-cycle pulse, time unchanged.
REQ-031 load_en with 12:34:56 in the same cycle as a tick -> time 12:34:56, no sec_tick; next tick -> 12:34:57.
REQ-032 run=0 across 5 clk_1Hz rises, then run=1 -> time unchanged, no burst; next rise advances ss by 1.
REQ-033 TOD_ALARM_EN: alarm_set 07:30, load 07:29:59, one tick -> alarm=1; alarm_ack -> alarm=0; undefined build elaborates without alarm ports.
